// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - central stall/flush controller for the 5-stage core.
//
// Drives the hold/clear inputs of the inter-stage registers and the PC hold.
// It resolves the following conditions, in priority order:
//   trap > FLUSH state > data-memory stall > mul/div > redirect > load-use
//   > fetch stall
//
// Outputs are combinational from the current state and the inputs. They are
// sampled by the pipeline registers at the next posedge. The state, the flush
// counter and md_pend are registered.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ifu_ready_i               fetch has an instruction available
//   id_rs{1,2}_en_i / _i      ID source-register usage and indices
//   ex_rd_wen_i, ex_is_load_i,
//   ex_rd_i                   EX destination info, used for load-use detection
//   redirect_i                EX branch/jump taken (level)
//   trap_i                    exception/interrupt commit (pulse)
//   md_start_i, md_done_i     mul/div launch and completion (pulses)
//   mem_req_i, mem_ready_i    MEM-stage access and data-memory response
//   hold_o   [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM
//   clear_o  [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
//   stall_cnt_o, flush_cnt_o  performance counters
//
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to build the performance
// counters. When it is undefined, both counter outputs are tied to 0.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FLUSH_CYC  = 2,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_ready_i,
  input  logic                  id_rs1_en_i,
  input  logic                  id_rs2_en_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_rd_wen_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  redirect_i,
  input  logic                  trap_i,
  input  logic                  md_start_i,
  input  logic                  md_done_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic [3:0]            hold_o,
  output logic [3:0]            clear_o,
  output logic [PERF_W-1:0]     stall_cnt_o,
  output logic [PERF_W-1:0]     flush_cnt_o
);

  // The counter holds at most FLUSH_CYC-1. Keep it at least 1 bit wide so
  // that FLUSH_CYC values of 0 and 1 still elaborate.
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (FLUSH_CYC > 0) ? CNT_W'(FLUSH_CYC - 1) : '0;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_pend_q, md_pend_d;

  logic mem_stall, load_use;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign load_use  = ex_is_load_i & ex_rd_wen_i & (ex_rd_i != '0) &
                     ((id_rs1_en_i & (id_rs1_i == ex_rd_i)) |
                      (id_rs2_en_i & (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_pend_d = md_pend_q;
    hold_o    = 4'b0000;
    clear_o   = 4'b0000;
    if (rst) begin
      // Reset clears every stage right away, even in the middle of a stall.
      clear_o = 4'b1111;
    end else if (trap_i) begin
      clear_o   = 4'b1111;
      md_pend_d = 1'b0;
      if (FLUSH_CYC > 0) begin
        state_d = FLUSH;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          hold_o  = 4'b0001;
          clear_o = 4'b0001;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        MEM_WAIT: begin
          // Redirect and load-use stay masked until the pipe is back in RUN.
          if (mem_stall) begin
            hold_o  = 4'b1111;
            clear_o = 4'b1000;
          end else begin
            state_d = RUN;
          end
        end
        MD_WAIT: begin
          if (mem_stall) begin
            hold_o  = 4'b1111;
            clear_o = 4'b1000;
            // A done pulse that arrives during a memory stall is remembered,
            // so the exit can happen once the stall clears.
            if (md_done_i) md_pend_d = 1'b1;
          end else if (md_done_i | md_pend_q) begin
            state_d   = RUN;
            md_pend_d = 1'b0;
          end else begin
            hold_o  = 4'b0111;
            clear_o = 4'b0100;
          end
        end
        default: begin
          if (mem_stall) begin
            hold_o  = 4'b1111;
            clear_o = 4'b1000;
            state_d = MEM_WAIT;
          end else if (md_start_i) begin
            hold_o  = 4'b0111;
            clear_o = 4'b0100;
            state_d = MD_WAIT;
          end else if (redirect_i) begin
            clear_o = 4'b0011;
          end else if (load_use) begin
            hold_o  = 4'b0011;
            clear_o = 4'b0010;
          end else if (!ifu_ready_i) begin
            hold_o  = 4'b0001;
            clear_o = 4'b0001;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      md_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_pend_q <= md_pend_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
  logic              flush_evt;

  assign flush_evt = trap_i | ((state_q == RUN) & redirect_i);

  // Both counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_o[0] && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (flush_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYC=2). Inputs change just after
// the negedge, and outputs are checked 1 time unit later.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ifu_ready_i, id_rs1_en_i, id_rs2_en_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        ex_rd_wen_i, ex_is_load_i, redirect_i, trap_i;
  logic        md_start_i, md_done_i, mem_req_i, mem_ready_i;
  logic [3:0]  hold_o, clear_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYC(2), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .ifu_ready_i(ifu_ready_i),
    .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_rd_wen_i(ex_rd_wen_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
    .redirect_i(redirect_i), .trap_i(trap_i),
    .md_start_i(md_start_i), .md_done_i(md_done_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .hold_o(hold_o), .clear_o(clear_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

  task automatic idle();
    ifu_ready_i = 1; id_rs1_en_i = 0; id_rs2_en_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    ex_rd_wen_i = 0; ex_is_load_i = 0; ex_rd_i = 0; redirect_i = 0; trap_i = 0;
    md_start_i = 0; md_done_i = 0; mem_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic nx();
    @(negedge clk);
    idle();
  endtask

  task automatic ld_use(input logic [4:0] rd);
    ex_is_load_i = 1; ex_rd_wen_i = 1; ex_rd_i = rd; id_rs2_en_i = 1; id_rs2_i = rd;
  endtask

  task automatic chk(input string tag, input logic [3:0] h, input logic [3:0] c);
    #1;
    checks++;
    assert (hold_o === h) else begin
      errs++; $error("FAIL %s hold_o got=%b exp=%b", tag, hold_o, h);
    end
    checks++;
    assert (clear_o === c) else begin
      errs++; $error("FAIL %s clear_o got=%b exp=%b", tag, clear_o, c);
    end
  endtask

  task automatic chk_perf(input string tag, input int s, input int f);
    checks++;
    assert (stall_cnt_o === 32'(s)) else begin
      errs++; $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt_o, s);
    end
    checks++;
    assert (flush_cnt_o === 32'(f)) else begin
      errs++; $error("FAIL %s flush_cnt got=%0d exp=%0d", tag, flush_cnt_o, f);
    end
  endtask

  initial begin
    idle();
    @(negedge clk); chk("reset", 4'b0000, 4'b1111); chk_perf("reset_perf", 0, 0);
    nx(); rst = 0; chk("idle", 4'b0000, 4'b0000);

    // Load-use stall
    nx(); ld_use(5'd5);                 chk("lu_rd5", 4'b0011, 4'b0010);
    nx();                               chk("lu_after", 4'b0000, 4'b0000);
    nx(); ld_use(5'd0);                 chk("lu_rd0", 4'b0000, 4'b0000);
    nx(); ld_use(5'd7); id_rs2_en_i = 0; id_rs1_i = 5'd7;
                                        chk("lu_rs1_dis", 4'b0000, 4'b0000);
    nx(); ld_use(5'd7); id_rs2_en_i = 0; id_rs1_en_i = 1; id_rs1_i = 5'd7;
                                        chk("lu_rs1", 4'b0011, 4'b0010);
    nx(); ld_use(5'd7); ex_is_load_i = 0; chk("lu_notload", 4'b0000, 4'b0000);

    // Fetch stall and redirect
    nx(); ifu_ready_i = 0;              chk("fetch", 4'b0001, 4'b0001);
    nx(); redirect_i = 1; ifu_ready_i = 0; chk("redirect", 4'b0000, 4'b0011);

    // Mul/div with done arriving 4 cycles after the start
    nx(); md_start_i = 1;               chk("md_launch", 4'b0111, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      nx();                             chk("md_wait", 4'b0111, 4'b0100);
    end
    nx(); md_done_i = 1;                chk("md_done", 4'b0000, 4'b0000);
    nx(); ld_use(5'd3);                 chk("md_run", 4'b0011, 4'b0010);

    // Memory stall, with a redirect held through the ready cycle
    for (int i = 0; i < 3; i++) begin
      nx(); mem_req_i = 1;              chk("mem_stall", 4'b1111, 4'b1000);
    end
    nx(); mem_req_i = 1; mem_ready_i = 1; redirect_i = 1;
                                        chk("mem_ready", 4'b0000, 4'b0000);
    nx(); redirect_i = 1;               chk("mem_run_redir", 4'b0000, 4'b0011);

    // Done pulse arrives during a memory stall in MD_WAIT
    nx(); md_start_i = 1;               chk("mdp_launch", 4'b0111, 4'b0100);
    nx(); mem_req_i = 1; md_done_i = 1; chk("mdp_stall_done", 4'b1111, 4'b1000);
    nx(); mem_req_i = 1;                chk("mdp_stall", 4'b1111, 4'b1000);
    nx(); mem_req_i = 1; mem_ready_i = 1; chk("mdp_exit", 4'b0000, 4'b0000);
    nx(); ld_use(5'd9);                 chk("mdp_run", 4'b0011, 4'b0010);

    // Trap, then a second trap that reloads the counter
    nx(); trap_i = 1;                   chk("trap", 4'b0000, 4'b1111);
    nx();                               chk("flush1", 4'b0001, 4'b0001);
    nx(); trap_i = 1;                   chk("trap_reload", 4'b0000, 4'b1111);
    nx();                               chk("flush1b", 4'b0001, 4'b0001);
    nx();                               chk("flush2b", 4'b0001, 4'b0001);
    nx();                               chk("flush_run", 4'b0000, 4'b0000);

    // Reset asserted in the middle of MD_WAIT
    nx(); md_start_i = 1;               chk("rmd_launch", 4'b0111, 4'b0100);
    nx();                               chk("rmd_wait", 4'b0111, 4'b0100);
    nx(); rst = 1;                      chk("rmd_reset", 4'b0000, 4'b1111);
    chk_perf("rmd_perf", 0, 0);
    nx(); rst = 0; ld_use(5'd4);        chk("rst_run_lu", 4'b0011, 4'b0010);
    nx();                               chk("rst_idle", 4'b0000, 4'b0000);
    nx(); ifu_ready_i = 0;              chk("p_fetch1", 4'b0001, 4'b0001);
    nx(); ifu_ready_i = 0;              chk("p_fetch2", 4'b0001, 4'b0001);
    nx(); redirect_i = 1;               chk("p_redir", 4'b0000, 4'b0011);
    nx(); trap_i = 1;                   chk("p_trap", 4'b0000, 4'b1111);
    nx();                               chk("p_flush1", 4'b0001, 4'b0001);
    nx();                               chk("p_flush2", 4'b0001, 4'b0001);
    nx();                               chk("p_end", 4'b0000, 4'b0000);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk_perf("perf_counts", 5, 2);
`else
    chk_perf("perf_tied", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Drives the clear and hold control inputs of every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
- Resolves load-use hazards, branch redirects, traps, multi-cycle mul/div and data-memory wait states through a small state machine and a flush counter.
- Clear has priority over hold at each pipeline register. This block therefore never needs to assert both on the same stage.

Parameters:
- REG_ADDR_W, 5, register index width.
- FLUSH_CYC, 2, cycles the PC stays frozen after a trap (0 = none).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- ifu_ready_i  input  1  fetch has an instruction available
- id_rs1_en_i  input  1  ID reads rs1
- id_rs2_en_i  input  1  ID reads rs2
- id_rs1_i  input  REG_ADDR_W  ID rs1 index
- id_rs2_i  input  REG_ADDR_W  ID rs2 index
- ex_rd_wen_i  input  1  EX instruction writes rd
- ex_is_load_i  input  1  EX instruction is a load
- ex_rd_i  input  REG_ADDR_W  EX rd index
- redirect_i  input  1  EX branch/jump taken (level, held while EX held)
- trap_i  input  1  exception/interrupt commit (1-cycle pulse)
- md_start_i  input  1  EX launches a mul/div (1-cycle pulse)
- md_done_i  input  1  mul/div result ready (1-cycle pulse)
- mem_req_i  input  1  MEM stage access active
- mem_ready_i  input  1  data memory responds this cycle
- hold_o  output  4  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM
- clear_o  output  4  [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
- stall_cnt_o  output  PERF_W  cycles with hold_o[0]=1
- flush_cnt_o  output  PERF_W  count of redirect and trap events

Behaviour:
- Reset
  - While rst=1: state=RUN, flush counter=0, md_pend=0, hold_o=0, clear_o=4'b1111.
  - Reset mid-stall aborts the stall immediately.
- Output timing
  - Outputs are combinational from state plus inputs, and are sampled by the pipeline registers at the next posedge.
  - State, counter and md_pend are registered.
- States: RUN, MEM_WAIT, MD_WAIT, FLUSH.
- Priority per cycle: trap > FLUSH state > mem stall > mul/div > redirect > load-use > fetch stall.
- trap_i (any state)
  - Outputs: clear_o=1111, hold_o=0, md_pend cleared.
  - Next: FLUSH with cnt=FLUSH_CYC-1, or RUN if FLUSH_CYC=0.
- FLUSH
  - Outputs: hold_o=0001, clear_o=0001.
  - cnt decrements; when cnt==0, next state is RUN.
  - trap_i during FLUSH reloads cnt.
- Mem stall (mem_req_i & ~mem_ready_i, in RUN, MEM_WAIT or MD_WAIT)
  - Outputs: hold_o=1111, clear_o=1000.
  - From RUN: next MEM_WAIT.
- MEM_WAIT
  - On the mem_ready_i cycle: hold_o=0, clear_o=0, next RUN.
  - redirect_i and load-use are ignored in this state.
- Mul/div launch (md_start_i in RUN, no mem stall)
  - Outputs: hold_o=0111, clear_o=0100.
  - Next: MD_WAIT.
- MD_WAIT
  - Outputs: same as launch (hold_o=0111, clear_o=0100) unless a mem stall is active; then use mem-stall outputs and stay in MD_WAIT.
  - md_done_i arriving during a mem stall sets md_pend.
  - Exit to RUN, with outputs 0, on the first cycle where (md_done_i | md_pend) and there is no mem stall. md_pend clears on exit.
- redirect_i (RUN only): clear_o=0011, hold_o=0.
- Load-use (RUN, no redirect)
  - Condition: ex_is_load_i & ex_rd_wen_i & ex_rd_i!=0 & ((id_rs1_en_i & id_rs1_i==ex_rd_i) | (id_rs2_en_i & id_rs2_i==ex_rd_i)).
  - Outputs: hold_o=0011, clear_o=0010, for exactly that cycle.
  - Rd index 0 never triggers a load-use stall.
- Fetch stall (RUN, ~ifu_ready_i, none of the above): hold_o=0001, clear_o=0001.
- Otherwise: hold_o=0, clear_o=0.
- Invariant: hold_o[i] and the clear bit of the same register are never both 1.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - stall_cnt_o increments each cycle hold_o[0]=1.
  - flush_cnt_o increments on each RUN cycle with a redirect and each cycle with trap_i=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load x5 in EX (rd=5), ID reads rs2=5 -> one cycle hold_o=0011, clear_o=0010, then 0000/0000. Repeat with rd=0 -> no stall.
- md_start_i, md_done_i 4 cycles later -> 4 cycles of hold_o=0111, clear_o=0100; released in the done cycle; state RUN.
- mem_req_i=1, mem_ready_i low for 3 cycles -> 3 cycles of hold_o=1111, clear_o=1000; on the ready cycle outputs 0.
- In MD_WAIT, mem stall overlaps md_done_i pulse -> md_pend set; RUN entered on the first non-stalled cycle.
- trap_i with FLUSH_CYC=2 -> clear_o=1111, then 2 cycles of hold_o=0001/clear_o=0001, then RUN. Redirect during MEM_WAIT -> no clear until RUN.
- rst pulsed mid MD_WAIT -> clear_o=1111, hold_o=0 immediately. With PIPE_HAZARD_CTRL_PERF_EN, stall_cnt_o=0 after reset and matches stalled cycles afterwards.
